// File: rtl/rr_arb_pkg.sv
// Shared definitions for the 4-way round-robin arbiter.
package rr_arb_pkg;

   localparam int unsigned N_REQ = 4;
   localparam int unsigned IDX_W = 2;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_e;

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first set request bit at or after ptr, wrapping.
module rr_pick4
   import rr_arb_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] ptr,
   output logic [IDX_W-1:0] idx,
   output logic             any
);

   // Scan from the far end back towards ptr so the nearest hit wins.
   always_comb begin
      idx = ptr;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (req[ptr + IDX_W'(i)]) idx = ptr + IDX_W'(i);
      end
   end

   assign any = |req;

endmodule

// File: rtl/rr_arb4.sv
// 4-way round-robin arbiter with done/drop release and a hold-time limit that
// preempts the owner when another requester is waiting. All outputs registered.
module rr_arb4
   import rr_arb_pkg::*;
#(
   parameter int unsigned MAX_HOLD = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_REQ-1:0] req,
   input  logic             done,
   output logic [IDX_W-1:0] gnt_idx,
   output logic             gnt_valid,
   output logic             preempt
);

   localparam int unsigned HOLD_W = 8;
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

   arb_state_e        state_q, state_d;
   logic [IDX_W-1:0]  ptr_q, ptr_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic              valid_q, valid_d;
   logic              preempt_q, preempt_d;

   logic [IDX_W-1:0]  pick_idx;
   logic              pick_any;
   logic [N_REQ-1:0]  owner_mask;
   logic              others;
   logic              timeout;
   logic              rel;

   rr_pick4 u_pick (
      .req (req),
      .ptr (ptr_q),
      .idx (pick_idx),
      .any (pick_any)
   );

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      idx_d      = idx_q;
      hold_d     = hold_q;
      valid_d    = valid_q;
      preempt_d  = 1'b0;
      owner_mask = N_REQ'(1) << idx_q;
      others     = |(req & ~owner_mask);
      timeout    = (hold_q == HOLD_LAST) && others;
      rel        = done || !req[idx_q] || timeout;

      unique case (state_q)
         IDLE: begin
            valid_d = 1'b0;
            if (pick_any) begin
               state_d = GRANT;
               valid_d = 1'b1;
               idx_d   = pick_idx;
               ptr_d   = pick_idx + 1'b1;
               hold_d  = '0;
            end
         end
         GRANT: begin
            if (rel) begin
               if (pick_any) begin
                  // ptr_q already points past the owner, so a lone owner regrants itself.
                  state_d   = GRANT;
                  valid_d   = 1'b1;
                  idx_d     = pick_idx;
                  ptr_d     = pick_idx + 1'b1;
                  hold_d    = '0;
                  preempt_d = timeout && !done && req[idx_q];
               end else begin
                  state_d = IDLE;
                  valid_d = 1'b0;
               end
            end else if (hold_q != HOLD_LAST) begin
               hold_d = hold_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         ptr_q     <= '0;
         idx_q     <= '0;
         hold_q    <= '0;
         valid_q   <= 1'b0;
         preempt_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         idx_q     <= idx_d;
         hold_q    <= hold_d;
         valid_q   <= valid_d;
         preempt_q <= preempt_d;
      end
   end

   assign gnt_idx   = idx_q;
   assign gnt_valid = valid_q;
   assign preempt   = preempt_q;

endmodule

// File: tb/tb_rr_arb4.sv
// Directed self-checking bench for rr_arb4 (MAX_HOLD = 8).
module tb_rr_arb4;

   logic       clk;
   logic       rst;
   logic [3:0] req;
   logic       done;
   logic [1:0] gnt_idx;
   logic       gnt_valid;
   logic       preempt;

   int n_cmp;
   int n_err;

   rr_arb4 #(
      .MAX_HOLD (8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .done      (done),
      .gnt_idx   (gnt_idx),
      .gnt_valid (gnt_valid),
      .preempt   (preempt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge and settle; inputs change and outputs sample here.
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst  = 1'b1;
      req  = 4'b0000;
      done = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset;
      rst  = 1'b1;
      req  = 4'b0000;
      done = 1'b0;
      #2;
      n_cmp++;
      if (gnt_valid !== 1'b0 || gnt_idx !== 2'd0 || preempt !== 1'b0) begin
         n_err++;
         $display("FAIL reset_asserted valid=%b idx=%0d pre=%b want 0/0/0",
                  gnt_valid, gnt_idx, preempt);
      end
      do_reset();
      for (int c = 0; c < 5; c++) begin
         tick();
         n_cmp++;
         if (gnt_valid !== 1'b0 || gnt_idx !== 2'd0 || preempt !== 1'b0) begin
            n_err++;
            $display("FAIL idle_no_req c%0d valid=%b idx=%0d pre=%b want 0/0/0",
                     c, gnt_valid, gnt_idx, preempt);
         end
      end
   endtask

   task automatic test_pick;
      do_reset();
      req = 4'b1010;
      tick();
      n_cmp++;
      if (gnt_valid !== 1'b1 || gnt_idx !== 2'd1) begin
         n_err++;
         $display("FAIL pick_first valid=%b idx=%0d want 1/1", gnt_valid, gnt_idx);
      end
      req = 4'b1000;
      tick();
      n_cmp++;
      if (gnt_valid !== 1'b1 || gnt_idx !== 2'd3 || preempt !== 1'b0) begin
         n_err++;
         $display("FAIL drop_handoff valid=%b idx=%0d pre=%b want 1/3/0",
                  gnt_valid, gnt_idx, preempt);
      end
      req = 4'b0000;
      tick();
      n_cmp++;
      if (gnt_valid !== 1'b0 || gnt_idx !== 2'd3) begin
         n_err++;
         $display("FAIL to_idle valid=%b idx=%0d want 0/3", gnt_valid, gnt_idx);
      end
      done = 1'b1;
      tick();
      done = 1'b0;
      n_cmp++;
      if (gnt_valid !== 1'b0 || gnt_idx !== 2'd3 || preempt !== 1'b0) begin
         n_err++;
         $display("FAIL done_in_idle valid=%b idx=%0d pre=%b want 0/3/0",
                  gnt_valid, gnt_idx, preempt);
      end
   endtask

   task automatic test_back_to_back;
      logic [1:0] exp_idx;
      do_reset();
      req = 4'b1111;
      tick();
      for (int k = 0; k < 5; k++) begin
         exp_idx = 2'(k);
         n_cmp++;
         if (gnt_valid !== 1'b1 || gnt_idx !== exp_idx || preempt !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_grant k%0d valid=%b idx=%0d pre=%b want 1/%0d/0",
                     k, gnt_valid, gnt_idx, preempt, exp_idx);
         end
         if (k < 4) begin
            tick();
            n_cmp++;
            if (gnt_valid !== 1'b1 || gnt_idx !== exp_idx) begin
               n_err++;
               $display("FAIL b2b_hold k%0d valid=%b idx=%0d want 1/%0d",
                        k, gnt_valid, gnt_idx, exp_idx);
            end
            done = 1'b1;
            tick();
            done = 1'b0;
         end
      end
   endtask

   task automatic test_timeout;
      do_reset();
      req = 4'b0011;
      tick();
      for (int c = 0; c < 8; c++) begin
         if (c > 0) tick();
         n_cmp++;
         if (gnt_valid !== 1'b1 || gnt_idx !== 2'd0 || preempt !== 1'b0) begin
            n_err++;
            $display("FAIL timeout_hold c%0d valid=%b idx=%0d pre=%b want 1/0/0",
                     c, gnt_valid, gnt_idx, preempt);
         end
      end
      tick();
      n_cmp++;
      if (gnt_valid !== 1'b1 || gnt_idx !== 2'd1 || preempt !== 1'b1) begin
         n_err++;
         $display("FAIL timeout_preempt valid=%b idx=%0d pre=%b want 1/1/1",
                  gnt_valid, gnt_idx, preempt);
      end
      tick();
      n_cmp++;
      if (gnt_idx !== 2'd1 || preempt !== 1'b0) begin
         n_err++;
         $display("FAIL preempt_pulse idx=%0d pre=%b want 1/0", gnt_idx, preempt);
      end
   endtask

   task automatic test_solo;
      do_reset();
      req = 4'b0001;
      for (int c = 0; c < 20; c++) begin
         tick();
         n_cmp++;
         if (gnt_valid !== 1'b1 || gnt_idx !== 2'd0 || preempt !== 1'b0) begin
            n_err++;
            $display("FAIL solo_hold c%0d valid=%b idx=%0d pre=%b want 1/0/0",
                     c, gnt_valid, gnt_idx, preempt);
         end
      end
      // Hold count is saturated, so a new waiter forces release on the next edge.
      req = 4'b0011;
      tick();
      n_cmp++;
      if (gnt_idx !== 2'd1 || preempt !== 1'b1) begin
         n_err++;
         $display("FAIL solo_saturated idx=%0d pre=%b want 1/1", gnt_idx, preempt);
      end
   endtask

   task automatic test_regrant;
      do_reset();
      req = 4'b0001;
      for (int c = 0; c < 4; c++) tick();
      done = 1'b1;
      tick();
      done = 1'b0;
      n_cmp++;
      if (gnt_valid !== 1'b1 || gnt_idx !== 2'd0 || preempt !== 1'b0) begin
         n_err++;
         $display("FAIL regrant valid=%b idx=%0d pre=%b want 1/0/0",
                  gnt_valid, gnt_idx, preempt);
      end
      req = 4'b0011;
      for (int c = 0; c < 7; c++) begin
         tick();
         n_cmp++;
         if (gnt_idx !== 2'd0 || preempt !== 1'b0) begin
            n_err++;
            $display("FAIL regrant_hold c%0d idx=%0d pre=%b want 0/0", c, gnt_idx, preempt);
         end
      end
      tick();
      n_cmp++;
      if (gnt_idx !== 2'd1 || preempt !== 1'b1) begin
         n_err++;
         $display("FAIL regrant_timeout idx=%0d pre=%b want 1/1", gnt_idx, preempt);
      end
   endtask

   task automatic test_reset_mid;
      do_reset();
      req = 4'b0100;
      tick();
      n_cmp++;
      if (gnt_valid !== 1'b1 || gnt_idx !== 2'd2) begin
         n_err++;
         $display("FAIL mid_pre_grant valid=%b idx=%0d want 1/2", gnt_valid, gnt_idx);
      end
      #2;
      rst = 1'b1;
      #1;
      n_cmp++;
      if (gnt_valid !== 1'b0 || gnt_idx !== 2'd0 || preempt !== 1'b0) begin
         n_err++;
         $display("FAIL mid_async_rst valid=%b idx=%0d pre=%b want 0/0/0",
                  gnt_valid, gnt_idx, preempt);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      n_cmp++;
      if (gnt_valid !== 1'b0) begin
         n_err++;
         $display("FAIL mid_released valid=%b want 0", gnt_valid);
      end
      tick();
      n_cmp++;
      if (gnt_valid !== 1'b1 || gnt_idx !== 2'd2) begin
         n_err++;
         $display("FAIL mid_regrant valid=%b idx=%0d want 1/2", gnt_valid, gnt_idx);
      end
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst   = 1'b1;
      req   = 4'b0000;
      done  = 1'b0;
      test_reset();
      test_pick();
      test_back_to_back();
      test_timeout();
      test_solo();
      test_regrant();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/rr_arb4.md
RR_ARB4 -- requirements
Module: rr_arb4

Interface
REQ-001 SHALL have parameter MAX_HOLD, default 8, maximum consecutive cycles one owner holds the grant while another requester waits (legal 2..255).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-004 SHALL have port req, input, 4, request vector; bit i is requester i.
REQ-005 SHALL have port done, input, 1, single-cycle release strobe from the current owner.
REQ-006 SHALL have port gnt_idx, output, 2, binary index of current owner; drives a 2-to-4 decoder select.
REQ-007 SHALL have port gnt_valid, output, 1, grant active; drives the decoder enable.
REQ-008 SHALL have port preempt, output, 1, one-cycle pulse marking a timeout-forced release.

Function
REQ-009 SHALL implement two states: IDLE (no owner) and GRANT (owner = gnt_idx).
REQ-010 SHALL register all outputs; no combinational path from any input to any output.
REQ-011 SHALL maintain a 2-bit priority pointer ptr; selection = first set bit of req scanning ptr, ptr+1, ... with wrap mod 4.
REQ-012 IDLE with req != 0 at edge N: SHALL enter GRANT, gnt_valid=1, gnt_idx=selected index, visible after edge N (1-cycle latency).
REQ-013 IDLE with req == 0: SHALL remain IDLE, gnt_valid=0, gnt_idx holds last value.
REQ-014 On every new grant to index k: SHALL set ptr = k+1 mod 4 and clear hold_cnt to 0.
REQ-015 GRANT: hold_cnt SHALL increment each cycle, saturating at MAX_HOLD-1.
REQ-016 GRANT release condition SHALL be: done=1, or req[owner]=0, or (hold_cnt==MAX_HOLD-1 and any other req bit set).
REQ-017 On release with req != 0: SHALL hand off directly to the next selection (from updated ptr) with gnt_valid staying 1, no idle bubble.
REQ-018 On release with req == 0: SHALL return to IDLE, gnt_valid=0 next cycle.
REQ-019 done=1 while owner still requests and no other requester: SHALL regrant same owner, hold_cnt reset to 0.
REQ-020 Timeout with no other requester: SHALL keep grant, no preempt, hold_cnt saturated.
REQ-021 preempt SHALL be 1 for exactly the cycle following a release caused solely by the timeout term.
REQ-022 done while in IDLE SHALL be ignored.
REQ-023 req changes during GRANT for non-owners SHALL not affect gnt_idx until release.

Reset
REQ-024 rst=1 SHALL immediately force state=IDLE, gnt_valid=0, gnt_idx=0, preempt=0, ptr=0, hold_cnt=0, regardless of clk.
REQ-025 Reset asserted mid-grant SHALL drop gnt_valid without waiting for an edge; first grant after release follows REQ-012 with ptr=0.

Structure
REQ-026 Shared package rr_arb_pkg SHALL hold N_REQ=4, IDX_W=2, state encoding IDLE=0/GRANT=1.
REQ-027 Selection logic SHALL be a combinational sub-module rr_pick4 (inputs req, ptr; outputs idx, any).
REQ-028 Block SHALL not produce one-hot grants; one-hot is the downstream decoder's job.

Verification
REQ-029 Reset then req=4'b0000 for 5 cycles -> gnt_valid=0, gnt_idx=00, preempt=0 throughout.
REQ-030 req=4'b1010 from IDLE, ptr=0 -> next cycle gnt_idx=01, gnt_valid=1; owner drops req[1] -> next cycle gnt_idx=11, gnt_valid=1.
REQ-031 req=4'b1111 held, done pulsed every 2 cycles -> gnt_idx sequence 00,01,10,11,00, gnt_valid never 0.
REQ-032 MAX_HOLD=8, req=4'b0011 held, no done -> owner 0 for 8 cycles, then gnt_idx=01 with preempt=1 for one cycle.
REQ-033 req=4'b0001 only, no done, 20 cycles -> gnt_idx=00 held, preempt never 1.
REQ-034 rst asserted between edges during grant to index 10 -> gnt_valid=0 immediately; after release with req=4'b0100 -> gnt_idx=10 one cycle later.
